// File: rtl/pwm_fade_multi.sv
// pwm_fade_multi: N-channel PWM generator with per-channel fading duty.
//
// Each channel has a target duty (loaded over the ld/ch_sel/target strobe)
// and an active duty that drives its PWM output. The active duty only
// changes at PWM frame boundaries, so the pins never see a truncated or
// stretched pulse. With rate == 0 the active duty jumps to the target at
// the next boundary. Otherwise it walks one LSB toward the target every
// rate+1 frames.
//
// Optional build macro: PWM_FADE_PHASE_EN
//   When defined, channel i compares its duty against a copy of the frame
//   counter advanced by i*(2^WIDTH/CHANNELS). This staggers the channel
//   rising edges across the frame. Frame and duty-update timing still follow
//   the unshifted counter.
//   When undefined, every channel compares against the same counter.

module pwm_fade_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int RATE_W   = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic [WIDTH-1:0]          target,
  input  logic [RATE_W-1:0]         rate,
  output logic [CHANNELS*WIDTH-1:0] duty_out,
  output logic [CHANNELS-1:0]       busy,
  output logic                      frame,
  output logic                      err,
  output logic [CHANNELS-1:0]       pwm_out
);

  // Last counter value of a frame. Crossing it is the frame boundary.
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]  DUTY_ONE = WIDTH'(1);
  localparam logic [RATE_W-1:0] PCNT_ONE = RATE_W'(1);
  // Channel count widened by one bit, so it can be compared against ch_sel
  // even when CHANNELS is a power of two.
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

  // Shared timing state.
  logic [WIDTH-1:0]  cnt_reg;
  logic              frame_reg;
  logic [RATE_W-1:0] pcnt_reg;
  logic              err_reg;

  // Decoded control shared by all channels.
  logic              boundary;
  logic              tick;
  logic              jump_mode;
  logic [CH_W:0]     ch_sel_ext;
  logic              ld_valid;
  logic              ld_bad;

  // The edge on which cnt wraps is the only edge where active duties move.
  assign boundary   = (cnt_reg == CNT_MAX);
  // The prescaler fires once its count has reached the programmed rate.
  // If rate is lowered below the current count, this fires at the next
  // boundary instead of waiting for the counter to wrap.
  assign tick       = (pcnt_reg >= rate);
  assign jump_mode  = (rate == '0);
  assign ch_sel_ext = {1'b0, ch_sel};
  assign ld_valid   = ld && (ch_sel_ext < CH_LIMIT);
  assign ld_bad     = ld && !(ch_sel_ext < CH_LIMIT);

  // Free-running frame counter.
  // frame is registered so that it is high during the cycle in which
  // cnt == 0 after a wrap. It stays low in the first frame after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      frame_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_reg + DUTY_ONE;
      frame_reg <= boundary;
    end
  end

  // Fade-rate prescaler. It advances once per frame boundary and restarts
  // after each tick, so a tick occurs every rate+1 frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_reg <= '0;
    end else if (boundary) begin
      if (tick) begin
        pcnt_reg <= '0;
      end else begin
        pcnt_reg <= pcnt_reg + PCNT_ONE;
      end
    end
  end

  // Sticky error flag for a load addressed to a channel that does not exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (ld_bad) begin
      err_reg <= 1'b1;
    end
  end

  assign frame = frame_reg;
  assign err   = err_reg;

  // Per-channel target, active duty and PWM comparator.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] duty_reg;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH-1:0] cmp_cnt;
    logic             pwm_reg;
    logic             sel_hit;

`ifdef PWM_FADE_PHASE_EN
    // Each channel's phase offset is a whole fraction of the frame.
    localparam longint PHASE_SPAN = (64'd1 << WIDTH) / CHANNELS;
    localparam logic [WIDTH-1:0] PHASE_OFF = WIDTH'(gi * PHASE_SPAN);
    // The addition wraps modulo 2^WIDTH because cmp_cnt has the counter width.
    assign cmp_cnt = cnt_reg + PHASE_OFF;
`else
    assign cmp_cnt = cnt_reg;
`endif

    assign sel_hit = ld_valid && (ch_sel == CH_W'(gi));

    // Next active duty at a boundary: jump, step by one LSB, or hold.
    // A single-LSB step toward the target cannot overshoot or wrap.
    always_comb begin
      duty_next = duty_reg;
      if (jump_mode) begin
        duty_next = target_reg;
      end else if (tick) begin
        if (duty_reg < target_reg) begin
          duty_next = duty_reg + DUTY_ONE;
        end else if (duty_reg > target_reg) begin
          duty_next = duty_reg - DUTY_ONE;
        end
      end
    end

    // Active duty moves only at the frame boundary.
    // Because the target register is read before any same-edge load lands,
    // a load that coincides with a boundary takes effect one update later.
    always_ff @(posedge clk) begin
      if (reset) begin
        duty_reg <= '0;
      end else if (boundary) begin
        duty_reg <= duty_next;
      end
    end

    // Target register written by the load strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        target_reg <= '0;
      end else if (sel_hit) begin
        target_reg <= target;
      end
    end

    // Registered comparator. It gives a duty of 0 that is always low and a
    // duty of all ones that is high for all but one count of the frame.
    always_ff @(posedge clk) begin
      if (reset) begin
        pwm_reg <= 1'b0;
      end else begin
        pwm_reg <= (cmp_cnt < duty_reg);
      end
    end

    assign duty_out[gi*WIDTH +: WIDTH] = duty_reg;
    assign busy[gi]                    = (duty_reg != target_reg);
    assign pwm_out[gi]                 = pwm_reg;
  end

endmodule

// File: tb/tb_pwm_fade_multi.sv
// Randomized self-checking bench for pwm_fade_multi.
// A cycle-level behavioural model, written directly from the frame, prescaler
// and fade rules with integer arithmetic, predicts every output on every
// cycle. Outputs are sampled on the falling clock edge.

module tb_pwm_fade_multi;

  localparam int CH   = 3;
  localparam int W    = 5;
  localparam int RW   = 3;
  localparam int CHW  = 2;
  localparam int SPAN = 1 << W;
  localparam int RMOD = 1 << RW;

  logic            clk = 1'b0;
  logic            reset;
  logic            ld;
  logic [CHW-1:0]  ch_sel;
  logic [W-1:0]    target;
  logic [RW-1:0]   rate;
  logic [CH*W-1:0] duty_out;
  logic [CH-1:0]   busy;
  logic            frame;
  logic            err;
  logic [CH-1:0]   pwm_out;

  always #5 clk = ~clk;

  pwm_fade_multi #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .RATE_W   (RW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld       (ld),
    .ch_sel   (ch_sel),
    .target   (target),
    .rate     (rate),
    .duty_out (duty_out),
    .busy     (busy),
    .frame    (frame),
    .err      (err),
    .pwm_out  (pwm_out)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int cur_rate     = 0;

  // Reference model state.
  int m_cnt;
  int m_pcnt;
  int m_frame;
  int m_err;
  int m_target [CH];
  int m_duty   [CH];
  int m_pwm    [CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pcnt = 0; m_frame = 0; m_err = 0;
    for (int i = 0; i < CH; i++) begin
      m_target[i] = 0; m_duty[i] = 0; m_pwm[i] = 0;
    end
  endtask

  // Advance the model by one clock edge, using the inputs held across it.
  task automatic model_step(input bit rst, input bit ld_i, input int ch_i,
                            input int tgt_i, input int rate_i);
    bit boundary;
    bit tk;
    int off;
    if (rst) begin
      model_reset();
      return;
    end
    boundary = (m_cnt == SPAN - 1);
    for (int i = 0; i < CH; i++) begin
`ifdef PWM_FADE_PHASE_EN
      off = i * (SPAN / CH);
`else
      off = 0;
`endif
      m_pwm[i] = (((m_cnt + off) % SPAN) < m_duty[i]) ? 1 : 0;
    end
    m_frame = boundary ? 1 : 0;
    if (boundary) begin
      tk = (m_pcnt >= rate_i);
      m_pcnt = tk ? 0 : (m_pcnt + 1) % RMOD;
      for (int i = 0; i < CH; i++) begin
        if (rate_i == 0)                m_duty[i] = m_target[i];
        else if (tk && m_duty[i] < m_target[i]) m_duty[i] = m_duty[i] + 1;
        else if (tk && m_duty[i] > m_target[i]) m_duty[i] = m_duty[i] - 1;
      end
    end
    if (ld_i) begin
      if (ch_i < CH) m_target[ch_i] = tgt_i;
      else           m_err = 1;
    end
    m_cnt = (m_cnt + 1) % SPAN;
  endtask

  task automatic check_outputs();
    logic [CH*W-1:0] exp_duty;
    logic [CH-1:0]   exp_busy;
    logic [CH-1:0]   exp_pwm;
    for (int i = 0; i < CH; i++) begin
      exp_duty[i*W +: W] = W'(m_duty[i]);
      exp_busy[i]        = (m_duty[i] != m_target[i]);
      exp_pwm[i]         = (m_pwm[i] != 0);
    end
    check_val("duty_out", 32'(duty_out), 32'(exp_duty));
    check_val("busy",     32'(busy),     32'(exp_busy));
    check_val("pwm_out",  32'(pwm_out),  32'(exp_pwm));
    check_val("frame",    32'(frame),    32'(m_frame));
    check_val("err",      32'(err),      32'(m_err));
  endtask

  // One cycle: pick inputs, drive them, advance the model, then sample the
  // DUT on the following falling edge.
  task automatic run_cycle(input bit rst, input int ld_den, input bit allow_bad);
    bit do_ld;
    int ch;
    int tgt;
    int pick;
    if ($urandom_range(0, 299) == 0) begin
      pick = int'($urandom_range(0, 4));
      cur_rate = (pick == 4) ? RMOD - 1 : pick;
    end
    do_ld = rst ? 1'b1 : ((ld_den > 0) && ($urandom_range(0, ld_den - 1) == 0));
    ch    = allow_bad ? int'($urandom_range(0, 3)) : int'($urandom_range(0, CH - 1));
    pick  = int'($urandom_range(0, 3));
    tgt   = (pick == 0) ? 0 : (pick == 1) ? SPAN - 1 : int'($urandom_range(0, SPAN - 1));
    reset  = rst;
    ld     = do_ld;
    ch_sel = CHW'(ch);
    target = W'(tgt);
    rate   = RW'(cur_rate);
    if (do_ld && !rst)
      $display("[TB] ld ch=%0d target=0x%0h rate=%0d cycle=%0d", ch, tgt, cur_rate, cyc);
    model_step(rst, do_ld, ch, tgt, cur_rate);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic run_phase(input int n, input bit rst, input int ld_den, input bit allow_bad);
    for (int k = 0; k < n; k++) begin
      if (tests_failed > 200) break;
      run_cycle(rst, ld_den, allow_bad);
    end
  endtask

  initial begin
    reset  = 1'b1;
    ld     = 1'b0;
    ch_sel = '0;
    target = '0;
    rate   = '0;
    model_reset();
    // Reset held for three cycles with loads asserted; reset must win.
    run_phase(3,    1'b1, 0,  1'b0);
    run_phase(6000, 1'b0, 40, 1'b0);
    run_phase(4000, 1'b0, 0,  1'b0);
    run_phase(8000, 1'b0, 20, 1'b0);
    run_phase(4000, 1'b0, 0,  1'b0);
    // Loads that include out-of-range channel indices.
    run_phase(2000, 1'b0, 40, 1'b1);
    // A mid-run reset must clear the sticky error and all channel state.
    run_phase(3,    1'b1, 0,  1'b1);
    run_phase(6000, 1'b0, 40, 1'b0);
    run_phase(2000, 1'b0, 0,  1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
